// File: rtl/mrs_issue_ctrl.sv
// Mode-register-set initiator: waits for controller idle, issues MR0 then MR2
// with tMRD/tMOD spacing, then pulses mrs_update_rdy with the new settings.
module mrs_issue_ctrl #(
    parameter int unsigned TMRD = 8,
    parameter int unsigned TMOD = 24
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mrs_req,
    input  logic [1:0]  bl_in,
    input  logic [3:0]  cl_in,
    input  logic [2:0]  cwl_in,
    input  logic        ctrl_idle,
    output logic        mrs_ack,
    output logic        mrs_busy,
    output logic        mrs_update_rdy,
    output logic [1:0]  bl_out,
    output logic [3:0]  cl_out,
    output logic [2:0]  cwl_out,
    output logic        cs_n,
    output logic        act_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [1:0]  bg,
    output logic [1:0]  ba,
    output logic [17:0] addr
);

    localparam int unsigned T_MAX = (TMRD > TMOD) ? TMRD : TMOD;
    localparam int unsigned CNT_W = (T_MAX > 2) ? $clog2(T_MAX) : 1;
    localparam logic [CNT_W-1:0] MRD_LOAD = CNT_W'(TMRD - 1);
    localparam logic [CNT_W-1:0] MOD_LOAD = CNT_W'(TMOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Command pin order: {cs_n, act_n, ras_n, cas_n, we_n}
    localparam logic [4:0] CMD_DES = 5'b11111;
    localparam logic [4:0] CMD_MRS = 5'b01000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_ISSUE_MR0,
        S_WAIT_MRD,
        S_ISSUE_MR2,
        S_WAIT_MOD,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       bl_lat_q, bl_lat_d;
    logic [3:0]       cl_lat_q, cl_lat_d;
    logic [2:0]       cwl_lat_q, cwl_lat_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             rdy_q, rdy_d;
    logic [1:0]       bl_out_q, bl_out_d;
    logic [3:0]       cl_out_q, cl_out_d;
    logic [2:0]       cwl_out_q, cwl_out_d;
    logic [4:0]       cmd_q, cmd_d;
    logic [1:0]       bg_q, bg_d;
    logic [1:0]       ba_q, ba_d;
    logic [17:0]      addr_q, addr_d;

    // Next state, counter and registered-output values derived from the next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bl_lat_d  = bl_lat_q;
        cl_lat_d  = cl_lat_q;
        cwl_lat_d = cwl_lat_q;
        bl_out_d  = bl_out_q;
        cl_out_d  = cl_out_q;
        cwl_out_d = cwl_out_q;
        cmd_d     = CMD_DES;
        bg_d      = 2'b00;
        ba_d      = 2'b00;
        addr_d    = 18'd0;

        case (state_q)
            S_IDLE: begin
                if (mrs_req) begin
                    bl_lat_d  = (bl_in == 2'b11) ? 2'b00 : bl_in;
                    cl_lat_d  = cl_in;
                    cwl_lat_d = cwl_in;
                    state_d   = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (ctrl_idle) state_d = S_ISSUE_MR0;
            end
            S_ISSUE_MR0: begin
                cnt_d   = MRD_LOAD;
                state_d = S_WAIT_MRD;
            end
            S_WAIT_MRD: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) state_d = S_ISSUE_MR2;
            end
            S_ISSUE_MR2: begin
                cnt_d   = MOD_LOAD;
                state_d = S_WAIT_MOD;
            end
            S_WAIT_MOD: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ack_d  = (state_q == S_IDLE) && mrs_req;
        busy_d = (state_d != S_IDLE);
        rdy_d  = (state_d == S_DONE);

        if (state_d == S_DONE) begin
            bl_out_d  = bl_lat_q;
            cl_out_d  = cl_lat_q;
            cwl_out_d = cwl_lat_q;
        end

        // MR0: BL in A1:A0, CL in A6:A4,A2, sequential burst (A3=0)
        if (state_d == S_ISSUE_MR0) begin
            cmd_d  = CMD_MRS;
            addr_d = {11'd0, cl_lat_q[3:1], 1'b0, cl_lat_q[0], bl_lat_q};
        end else if (state_d == S_ISSUE_MR2) begin
            cmd_d  = CMD_MRS;
            ba_d   = 2'b10;
            addr_d = {12'd0, cwl_lat_q, 3'b000};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bl_lat_q  <= 2'b00;
            cl_lat_q  <= 4'd0;
            cwl_lat_q <= 3'd0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
            bl_out_q  <= 2'b00;
            cl_out_q  <= 4'd0;
            cwl_out_q <= 3'd0;
            cmd_q     <= CMD_DES;
            bg_q      <= 2'b00;
            ba_q      <= 2'b00;
            addr_q    <= 18'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bl_lat_q  <= bl_lat_d;
            cl_lat_q  <= cl_lat_d;
            cwl_lat_q <= cwl_lat_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
            bl_out_q  <= bl_out_d;
            cl_out_q  <= cl_out_d;
            cwl_out_q <= cwl_out_d;
            cmd_q     <= cmd_d;
            bg_q      <= bg_d;
            ba_q      <= ba_d;
            addr_q    <= addr_d;
        end
    end

    assign mrs_ack        = ack_q;
    assign mrs_busy       = busy_q;
    assign mrs_update_rdy = rdy_q;
    assign bl_out         = bl_out_q;
    assign cl_out         = cl_out_q;
    assign cwl_out        = cwl_out_q;
    assign {cs_n, act_n, ras_n, cas_n, we_n} = cmd_q;
    assign bg             = bg_q;
    assign ba             = ba_q;
    assign addr           = addr_q;

endmodule

// File: tb/tb_mrs_issue_ctrl.sv
// Bench for mrs_issue_ctrl: per-cycle timestamp reference model, directed
// transaction table, hand-written corner sequences and randomized traffic.
module tb_mrs_issue_ctrl;

    localparam int TMRD = 8;
    localparam int TMOD = 24;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mrs_req;
    logic [1:0]  bl_in;
    logic [3:0]  cl_in;
    logic [2:0]  cwl_in;
    logic        ctrl_idle;
    logic        mrs_ack, mrs_busy, mrs_update_rdy;
    logic [1:0]  bl_out;
    logic [3:0]  cl_out;
    logic [2:0]  cwl_out;
    logic        cs_n, act_n, ras_n, cas_n, we_n;
    logic [1:0]  bg, ba;
    logic [17:0] addr;

    mrs_issue_ctrl #(.TMRD(TMRD), .TMOD(TMOD)) dut (
        .clock(clock), .reset_n(reset_n), .mrs_req(mrs_req),
        .bl_in(bl_in), .cl_in(cl_in), .cwl_in(cwl_in), .ctrl_idle(ctrl_idle),
        .mrs_ack(mrs_ack), .mrs_busy(mrs_busy), .mrs_update_rdy(mrs_update_rdy),
        .bl_out(bl_out), .cl_out(cl_out), .cwl_out(cwl_out),
        .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .bg(bg), .ba(ba), .addr(addr)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a captured request plus the edge at which MR0 appears
    int         edge_k = 0;
    bit         m_active, m_waiting;
    int         m_t0;
    logic       e_ack;
    logic [1:0] m_bl, m_blo;
    logic [3:0] m_cl, m_clo;
    logic [2:0] m_cwl, m_cwlo;

    task automatic model_reset();
        m_active = 0; m_waiting = 0; m_t0 = 0; e_ack = 1'b0;
        m_bl = 2'd0; m_cl = 4'd0; m_cwl = 3'd0;
        m_blo = 2'd0; m_clo = 4'd0; m_cwlo = 3'd0;
    endtask

    task automatic model_step(input logic req, input logic idle, input logic [1:0] bl,
                              input logic [3:0] cl, input logic [2:0] cwl);
        edge_k++;
        e_ack = 1'b0;
        if (m_active && !m_waiting && edge_k == m_t0 + TMRD + TMOD + 1) begin
            m_active = 0;
        end else if (!m_active) begin
            if (req) begin
                m_bl  = (bl == 2'd3) ? 2'd0 : bl;
                m_cl  = cl;
                m_cwl = cwl;
                m_active = 1; m_waiting = 1; e_ack = 1'b1;
            end
        end else if (m_waiting && idle) begin
            m_waiting = 0;
            m_t0 = edge_k;
        end
        if (m_active && !m_waiting && edge_k == m_t0 + TMRD + TMOD) begin
            m_blo = m_bl; m_clo = m_cl; m_cwlo = m_cwl;
        end
    endtask

    function automatic logic [38:0] exp_vec();
        logic        run, mr0, mr2, done;
        logic [4:0]  cmd;
        logic [1:0]  eba;
        logic [17:0] ea;
        run  = m_active && !m_waiting;
        mr0  = run && (edge_k == m_t0);
        mr2  = run && (edge_k == m_t0 + TMRD);
        done = run && (edge_k == m_t0 + TMRD + TMOD);
        cmd  = (mr0 || mr2) ? 5'b01000 : 5'b11111;
        eba  = mr2 ? 2'd2 : 2'd0;
        if (mr0)      ea = 18'(int'(m_bl) + 4 * int'(m_cl[0]) + 16 * (int'(m_cl) / 2));
        else if (mr2) ea = 18'(8 * int'(m_cwl));
        else          ea = 18'd0;
        return {e_ack, 1'(m_active), done, m_blo, m_clo, m_cwlo, cmd, 2'b00, eba, ea};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, got, exp, edge_k);
        end
    endtask

    task automatic check_vec(input string name);
        logic [38:0] act;
        act = {mrs_ack, mrs_busy, mrs_update_rdy, bl_out, cl_out, cwl_out,
               cs_n, act_n, ras_n, cas_n, we_n, bg, ba, addr};
        check(name, 64'(act), 64'(exp_vec()));
    endtask

    // One clock: model consumes the sampled inputs, outputs compared 1 ns later
    task automatic cycle();
        @(posedge clock);
        if (!reset_n) model_reset();
        else model_step(mrs_req, ctrl_idle, bl_in, cl_in, cwl_in);
        #1;
        check_vec("cycle_outputs");
    endtask

    bit          r_done;
    int          r_cmds, r_req_edge, r_mr0_edge, r_mr2_edge, r_rdy_edge;
    logic [17:0] r_mr0_addr, r_mr2_addr;
    logic [1:0]  r_bl;
    logic [3:0]  r_cl;
    logic [2:0]  r_cwl;

    // One request with ctrl_idle held low for d cycles after capture
    task automatic run_txn(input logic [1:0] bl, input logic [3:0] cl, input logic [2:0] cwl, input int d);
        r_done = 0; r_cmds = 0; r_req_edge = -1; r_mr0_edge = -1; r_mr2_edge = -1; r_rdy_edge = -1;
        r_mr0_addr = '1; r_mr2_addr = '1;
        bl_in = bl; cl_in = cl; cwl_in = cwl; mrs_req = 1'b1;
        for (int k = 0; k < 300 && !r_done; k++) begin
            ctrl_idle = (k > d);
            cycle();
            if (k == 0) r_req_edge = edge_k;
            if (mrs_ack) mrs_req = 1'b0;
            if (!cs_n) begin
                r_cmds++;
                if (ba == 2'b00) begin r_mr0_addr = addr; r_mr0_edge = edge_k; end
                else begin r_mr2_addr = addr; r_mr2_edge = edge_k; end
            end
            if (mrs_update_rdy) begin
                r_done = 1; r_rdy_edge = edge_k;
                r_bl = bl_out; r_cl = cl_out; r_cwl = cwl_out;
            end
        end
        mrs_req = 1'b0; ctrl_idle = 1'b1;
        check("txn_completed", 64'(r_done), 64'(1));
        cycle();
    endtask

    typedef struct {
        logic [1:0]  bl;
        logic [3:0]  cl;
        logic [2:0]  cwl;
        int          d;
        logic [17:0] mr0_addr;
        logic [17:0] mr2_addr;
        logic [1:0]  bl_out;
        int          lat;
    } vec_t;

    vec_t vecs[4];

    int acks_first, stray, rdye, ack2e, cmds, cmds2, mr0e, rdy_cnt;
    bit done2;

    initial begin
        vecs[0] = '{bl: 2'b10, cl: 4'b0101, cwl: 3'b011, d: 0,  mr0_addr: 18'h00026, mr2_addr: 18'h00018, bl_out: 2'b10, lat: 34};
        vecs[1] = '{bl: 2'b11, cl: 4'b1010, cwl: 3'b101, d: 10, mr0_addr: 18'h00050, mr2_addr: 18'h00028, bl_out: 2'b00, lat: 44};
        vecs[2] = '{bl: 2'b01, cl: 4'b1111, cwl: 3'b111, d: 3,  mr0_addr: 18'h00075, mr2_addr: 18'h00038, bl_out: 2'b01, lat: 37};
        vecs[3] = '{bl: 2'b00, cl: 4'b0001, cwl: 3'b000, d: 1,  mr0_addr: 18'h00004, mr2_addr: 18'h00000, bl_out: 2'b00, lat: 35};

        reset_n = 1'b0; mrs_req = 1'b0; ctrl_idle = 1'b1;
        bl_in = 2'd0; cl_in = 4'd0; cwl_in = 3'd0;
        model_reset();

        // Reset values, then deselect with no request
        repeat (3) cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("idle_deselect", 64'({cs_n, act_n, ras_n, cas_n, we_n}), 64'(5'b11111));
        end

        // Directed transaction table
        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].bl, vecs[i].cl, vecs[i].cwl, vecs[i].d);
            check($sformatf("row%0d_mr0_addr", i), 64'(r_mr0_addr), 64'(vecs[i].mr0_addr));
            check($sformatf("row%0d_mr2_addr", i), 64'(r_mr2_addr), 64'(vecs[i].mr2_addr));
            check($sformatf("row%0d_bl_out", i), 64'(r_bl), 64'(vecs[i].bl_out));
            check($sformatf("row%0d_cl_out", i), 64'(r_cl), 64'(vecs[i].cl));
            check($sformatf("row%0d_cwl_out", i), 64'(r_cwl), 64'(vecs[i].cwl));
            check($sformatf("row%0d_latency", i), 64'(r_rdy_edge - r_req_edge + 1), 64'(vecs[i].lat));
            check($sformatf("row%0d_mr0_latency", i), 64'(r_mr0_edge - r_req_edge + 1), 64'(vecs[i].d + 2));
            check($sformatf("row%0d_mrd_spacing", i), 64'(r_mr2_edge - r_mr0_edge), 64'(TMRD));
            check($sformatf("row%0d_cmd_count", i), 64'(r_cmds), 64'(2));
        end

        // Request pulsed during WAIT_MOD is ignored; one held through DONE is taken next IDLE
        bl_in = 2'b01; cl_in = 4'h9; cwl_in = 3'h2; ctrl_idle = 1'b1;
        acks_first = 0; stray = 0; rdye = -1; ack2e = -1; cmds = 0;
        for (int k = 0; k < 200 && ack2e < 0; k++) begin
            mrs_req = (k == 0) || (k == 14) || (k == 15) || (k >= 25);
            cycle();
            if (!cs_n && rdye < 0) cmds++;
            if (mrs_update_rdy) rdye = edge_k;
            if (mrs_ack) begin
                if (k == 0) acks_first++;
                else if (rdye < 0) stray++;
                else ack2e = edge_k;
            end
        end
        mrs_req = 1'b0;
        check("busy_first_ack", 64'(acks_first), 64'(1));
        check("busy_req_no_ack", 64'(stray), 64'(0));
        check("busy_req_no_extra_mrs", 64'(cmds), 64'(2));
        check("held_req_ack_after_done", 64'(ack2e - rdye), 64'(2));
        cmds2 = 0; done2 = 0;
        for (int k = 0; k < 100 && !done2; k++) begin
            cycle();
            if (!cs_n) cmds2++;
            if (mrs_update_rdy) done2 = 1;
        end
        check("second_txn_done", 64'(done2), 64'(1));
        check("second_txn_cmds", 64'(cmds2), 64'(2));
        cycle();

        // Asynchronous reset during WAIT_MRD
        bl_in = 2'b10; cl_in = 4'h5; cwl_in = 3'h3; ctrl_idle = 1'b1; mrs_req = 1'b1;
        mr0e = -1;
        for (int k = 0; k < 40 && !(mr0e >= 0 && edge_k == mr0e + 3); k++) begin
            cycle();
            if (mrs_ack) mrs_req = 1'b0;
            if (!cs_n) mr0e = edge_k;
        end
        check("reset_test_reached_mrd", 64'(mr0e >= 0), 64'(1));
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_vec("async_reset_outputs");
        cycle();
        cycle();
        reset_n = 1'b1;
        cmds = 0; rdy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (!cs_n) cmds++;
            if (mrs_update_rdy) rdy_cnt++;
        end
        check("after_reset_no_mr2", 64'(cmds), 64'(0));
        check("after_reset_no_update", 64'(rdy_cnt), 64'(0));
        run_txn(2'b10, 4'b0101, 3'b011, 0);
        check("rerequest_mr0_addr", 64'(r_mr0_addr), 64'(18'h00026));
        check("rerequest_mr2_addr", 64'(r_mr2_addr), 64'(18'h00018));
        check("rerequest_latency", 64'(r_rdy_edge - r_req_edge + 1), 64'(34));

        // Randomized traffic against the model, with occasional async resets
        rdy_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            mrs_req   = ($urandom_range(0, 3) == 0);
            bl_in     = 2'($urandom);
            cl_in     = 4'($urandom);
            cwl_in    = 3'($urandom);
            ctrl_idle = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 799) == 0) begin
                #2 reset_n = 1'b0;
                #1;
                model_reset();
                check_vec("rand_async_reset");
                cycle();
                reset_n = 1'b1;
            end
            cycle();
            if (mrs_update_rdy) rdy_cnt++;
        end
        check("rand_updates_seen", 64'(rdy_cnt > 10), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
